// File: rtl/stream_cypher_pkg.sv
// Shared definitions for the LFSR stream cypher blocks.
// Holds the top-level FSM state encoding and the default keystream
// polynomial and seed used by lfsr_stream_cypher and galois_lfsr.
package stream_cypher_pkg;

  typedef enum logic [1:0] {
    StReady = 2'd0,
    StGen   = 2'd1,
    StOut   = 2'd2
  } state_e;

  // x^16 + x^14 + x^13 + x^11 + 1 in Galois (right-shift) form.
  localparam logic [15:0] DefaultTaps = 16'hB400;
  localparam logic [15:0] DefaultSeed = 16'hACE1;

endpackage

// File: rtl/galois_lfsr.sv
// Right-shifting Galois LFSR with a synchronous seed load.
// Ports:
//   clk      - rising-edge clock
//   rst      - synchronous active-high reset, state <= RESET_SEED
//   load     - load load_val (all-zero value is replaced by 1)
//   load_val - seed value sampled when load=1
//   step     - advance one position; ignored when load=1
//   state    - current LFSR register, bit 0 is the output bit
module galois_lfsr
  import stream_cypher_pkg::*;
#(
  parameter int unsigned       WIDTH      = 16,
  parameter logic [WIDTH-1:0]  TAPS       = WIDTH'(DefaultTaps),
  parameter logic [WIDTH-1:0]  RESET_SEED = WIDTH'(DefaultSeed)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             step,
  output logic [WIDTH-1:0] state
);

  logic [WIDTH-1:0] state_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RESET_SEED;
    end else if (load) begin
      // All-zero is the lock-up state of an XOR LFSR; force a set LSB instead.
      state_q <= (load_val == '0) ? WIDTH'(1) : load_val;
    end else if (step) begin
      state_q <= (state_q >> 1) ^ (state_q[0] ? TAPS : '0);
    end
  end

  assign state = state_q;

endmodule

// File: rtl/lfsr_stream_cypher.sv
// Word-serial LFSR stream cypher: each accepted word is XORed with DATA_W
// keystream bits taken one per cycle from a Galois LFSR. Encrypt and
// decrypt are the same operation.
// Ports:
//   clk, rst              - clock and synchronous active-high reset
//   seed_load, seed       - one-cycle pulse reloading the LFSR; aborts any word
//   in_valid/ready/data   - plaintext or ciphertext input channel
//   out_valid/ready/data  - XOR result channel
//   word_cnt              - wrapping count of words delivered on out
module lfsr_stream_cypher
  import stream_cypher_pkg::*;
#(
  parameter int unsigned        DATA_W     = 8,
  parameter int unsigned        LFSR_W     = 16,
  parameter logic [LFSR_W-1:0]  TAPS       = LFSR_W'(DefaultTaps),
  parameter logic [LFSR_W-1:0]  RESET_SEED = LFSR_W'(DefaultSeed)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              seed_load,
  input  logic [LFSR_W-1:0] seed,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [15:0]       word_cnt
);

  localparam int unsigned     CntW    = $clog2(DATA_W + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(DATA_W - 1);

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] ks_q;
  logic [DATA_W-1:0] ks_next;
  logic [DATA_W-1:0] out_data_q;
  logic [15:0]       word_cnt_q;
  logic [LFSR_W-1:0] lfsr_state;
  logic              gen_last;
  logic              in_fire;
  logic              out_fire;
  logic              lfsr_step;
  logic              unused_lfsr_hi;

  galois_lfsr #(
    .WIDTH      (LFSR_W),
    .TAPS       (TAPS),
    .RESET_SEED (RESET_SEED)
  ) u_lfsr (
    .clk      (clk),
    .rst      (rst),
    .load     (seed_load),
    .load_val (seed),
    .step     (lfsr_step),
    .state    (lfsr_state)
  );

  // Only the output bit of the LFSR feeds the keystream.
  assign unused_lfsr_hi = ^lfsr_state[LFSR_W-1:1];

  // seed_load masks both handshakes so an aborted word is never counted.
  assign gen_last  = (cnt_q == CntLast);
  assign in_fire   = in_valid & in_ready & ~seed_load;
  assign out_fire  = out_valid & out_ready & ~seed_load;
  assign lfsr_step = (state_q == StGen) & ~seed_load;
  assign ks_next   = ks_q | (DATA_W'(lfsr_state[0]) << cnt_q);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StReady;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    if (seed_load) begin
      state_d = StReady;
    end else begin
      unique case (state_q)
        StReady: if (in_fire)  state_d = StGen;
        StGen:   if (gen_last) state_d = StOut;
        StOut:   if (out_fire) state_d = StReady;
        default:               state_d = StReady;
      endcase
    end
  end

  // Outputs decoded from registered state only.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      StReady: in_ready  = 1'b1;
      StOut:   out_valid = 1'b1;
      default: ;
    endcase
  end

  // Datapath.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      data_q     <= '0;
      ks_q       <= '0;
      out_data_q <= '0;
      word_cnt_q <= '0;
    end else begin
      if (in_fire) begin
        data_q <= in_data;
        ks_q   <= '0;
        cnt_q  <= '0;
      end
      if (lfsr_step) begin
        ks_q  <= ks_next;
        cnt_q <= cnt_q + CntW'(1);
        if (gen_last) begin
          out_data_q <= data_q ^ ks_next;
        end
      end
      if (out_fire) begin
        word_cnt_q <= word_cnt_q + 16'd1;
      end
      if (seed_load) begin
        cnt_q <= '0;
      end
    end
  end

  assign out_data = out_data_q;
  assign word_cnt = word_cnt_q;

endmodule

// File: tb/tb_lfsr_stream_cypher.sv
module tb_lfsr_stream_cypher;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        seed_load = 1'b0;
  logic [15:0] seed = 16'h0000;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_data = 8'h00;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [7:0]  out_data;
  logic [15:0] word_cnt;

  // Second instance, chained after the first for the inverse test.
  logic        chain_en = 1'b0;
  logic        b_seed_load = 1'b0;
  logic        a_out_ready;
  logic        b_in_valid;
  logic        b_in_ready;
  logic        b_out_valid;
  logic [7:0]  b_out_data;
  logic [15:0] b_word_cnt;

  int checks = 0;
  int errors = 0;
  int exp_wc = 0;

  always #5 clk = ~clk;

  assign a_out_ready = chain_en ? b_in_ready : out_ready;
  assign b_in_valid  = chain_en & out_valid;

  lfsr_stream_cypher dut (
    .clk       (clk),
    .rst       (rst),
    .seed_load (seed_load),
    .seed      (seed),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (a_out_ready),
    .out_data  (out_data),
    .word_cnt  (word_cnt)
  );

  lfsr_stream_cypher dut_b (
    .clk       (clk),
    .rst       (rst),
    .seed_load (b_seed_load),
    .seed      (seed),
    .in_valid  (b_in_valid),
    .in_ready  (b_in_ready),
    .in_data   (out_data),
    .out_valid (b_out_valid),
    .out_ready (1'b1),
    .out_data  (b_out_data),
    .word_cnt  (b_word_cnt)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic load_seed(input logic [15:0] s);
    seed = s;
    seed_load = 1'b1;
    step();
    seed_load = 1'b0;
  endtask

  // Present a word until accepted; ok=0 if in_ready never showed up.
  task automatic accept_word(input logic [7:0] d, output bit ok);
    int n;
    n = 0;
    in_data = d;
    in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      step();
      n++;
    end
    ok = in_ready;
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 100) begin
      step();
      lat++;
    end
  endtask

  // Full transfer with out_ready held high; lat counts edges after accept.
  task automatic xfer(input logic [7:0] d, output logic [7:0] res, output int lat, output bit ok);
    accept_word(d, ok);
    wait_out(lat);
    res = out_data;
    step();
    if (ok && lat < 100) exp_wc = (exp_wc + 1) % 65536;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    exp_wc = 0;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data got %h want 00", out_data); end
    checks++; if (word_cnt !== 16'h0000) begin errors++; $display("FAIL reset_word_cnt got %h want 0000", word_cnt); end
    checks++; if (dut.u_lfsr.state !== 16'hACE1) begin errors++; $display("FAIL reset_lfsr got %h want ACE1", dut.u_lfsr.state); end
  endtask

  task automatic test_basic;
    logic [7:0] res; int lat; bit ok;
    xfer(8'hAA, res, lat, ok);
    checks++; if (!ok || lat != 8) begin errors++; $display("FAIL basic_latency got %0d want 8", lat); end
    checks++; if (res !== 8'h4B) begin errors++; $display("FAIL basic_data got %h want 4B", res); end
    checks++; if (word_cnt !== 16'd1) begin errors++; $display("FAIL basic_word_cnt got %h want 0001", word_cnt); end
    checks++; if (dut.u_lfsr.state !== 16'hC2C4) begin errors++; $display("FAIL basic_lfsr got %h want C2C4", dut.u_lfsr.state); end
  endtask

  task automatic test_zero_seed;
    logic [7:0] res; int lat; bit ok;
    load_seed(16'h0000);
    checks++; if (dut.u_lfsr.state !== 16'h0001) begin errors++; $display("FAIL zero_seed_lfsr got %h want 0001", dut.u_lfsr.state); end
    checks++; if (word_cnt !== 16'(exp_wc)) begin errors++; $display("FAIL zero_seed_word_cnt got %h want %h", word_cnt, 16'(exp_wc)); end
    xfer(8'h00, res, lat, ok);
    checks++; if (res !== 8'h01) begin errors++; $display("FAIL zero_seed_data got %h want 01", res); end
    checks++; if (dut.u_lfsr.state !== 16'h0168) begin errors++; $display("FAIL zero_seed_lfsr_after got %h want 0168", dut.u_lfsr.state); end
  endtask

  task automatic test_seed_vs_input;
    logic [7:0] res; int lat; bit ok; bit seen;
    seed = 16'hACE1;
    in_data = 8'h77;
    in_valid = 1'b1;
    seed_load = 1'b1;
    step();
    seed_load = 1'b0;
    in_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (out_valid || !in_ready) seen = 1'b1;
      step();
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL conflict_not_accepted got %b want 0", seen); end
    checks++; if (dut.u_lfsr.state !== 16'hACE1) begin errors++; $display("FAIL conflict_lfsr got %h want ACE1", dut.u_lfsr.state); end
    xfer(8'hAA, res, lat, ok);
    checks++; if (res !== 8'h4B) begin errors++; $display("FAIL conflict_next_data got %h want 4B", res); end
  endtask

  task automatic test_stall;
    int lat; bit ok; logic [15:0] wc0;
    load_seed(16'hACE1);
    out_ready = 1'b0;
    accept_word(8'hAA, ok);
    wait_out(lat);
    wc0 = word_cnt;
    checks++; if (!ok || !out_valid) begin errors++; $display("FAIL stall_reach_out got %b want 1", out_valid); end
    for (int i = 0; i < 20; i++) begin
      checks++; if (out_data !== 8'h4B) begin errors++; $display("FAIL stall_data cyc %0d got %h want 4B", i, out_data); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready cyc %0d got %b want 0", i, in_ready); end
      checks++; if (dut.u_lfsr.state !== 16'hC2C4) begin errors++; $display("FAIL stall_lfsr cyc %0d got %h want C2C4", i, dut.u_lfsr.state); end
      step();
    end
    out_ready = 1'b1;
    step();
    exp_wc = (exp_wc + 1) % 65536;
    checks++; if (word_cnt !== wc0 + 16'd1) begin errors++; $display("FAIL stall_release_cnt got %h want %h", word_cnt, wc0 + 16'd1); end
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL stall_release_state got %b%b want 01", out_valid, in_ready); end
    step();
    step();
    checks++; if (word_cnt !== wc0 + 16'd1) begin errors++; $display("FAIL stall_single_fire got %h want %h", word_cnt, wc0 + 16'd1); end
  endtask

  task automatic test_seed_mid_gen;
    logic [7:0] res; int lat; bit ok; bit seen; logic [15:0] wc0;
    load_seed(16'hACE1);
    wc0 = word_cnt;
    accept_word(8'h55, ok);
    step();
    step();
    load_seed(16'h1234);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (out_valid || !in_ready) seen = 1'b1;
      step();
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL midgen_no_output got %b want 0", seen); end
    checks++; if (word_cnt !== wc0) begin errors++; $display("FAIL midgen_word_cnt got %h want %h", word_cnt, wc0); end
    checks++; if (dut.u_lfsr.state !== 16'h1234) begin errors++; $display("FAIL midgen_lfsr got %h want 1234", dut.u_lfsr.state); end
    xfer(8'h00, res, lat, ok);
    checks++; if (res !== 8'h34) begin errors++; $display("FAIL midgen_next_data got %h want 34", res); end
    checks++; if (dut.u_lfsr.state !== 16'h3E32) begin errors++; $display("FAIL midgen_lfsr_after got %h want 3E32", dut.u_lfsr.state); end
  endtask

  task automatic test_rst_mid_gen;
    logic [7:0] res; int lat; bit ok;
    accept_word(8'h12, ok);
    step();
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_wc = 0;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_state got %b%b want 10", in_ready, out_valid); end
    checks++; if (word_cnt !== 16'd0) begin errors++; $display("FAIL rst_mid_word_cnt got %h want 0000", word_cnt); end
    xfer(8'hAA, res, lat, ok);
    checks++; if (res !== 8'h4B) begin errors++; $display("FAIL rst_mid_data got %h want 4B", res); end
    checks++; if (word_cnt !== 16'd1) begin errors++; $display("FAIL rst_mid_word_cnt_after got %h want 0001", word_cnt); end
  endtask

  task automatic test_chain;
    logic [7:0] pt [5] = '{8'hAA, 8'hF0, 8'h0F, 8'h55, 8'hFF};
    bit ok; int n;
    seed = 16'h1234;
    seed_load = 1'b1;
    b_seed_load = 1'b1;
    step();
    seed_load = 1'b0;
    b_seed_load = 1'b0;
    chain_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      accept_word(pt[i], ok);
      n = 0;
      while (!b_out_valid && n < 100) begin
        if (i == 0 && out_valid) begin
          checks++; if (out_data !== 8'h9E) begin errors++; $display("FAIL chain_cipher0 got %h want 9E", out_data); end
        end
        step();
        n++;
      end
      checks++; if (!ok || b_out_data !== pt[i]) begin errors++; $display("FAIL chain_word%0d got %h want %h", i, b_out_data, pt[i]); end
      step();
      exp_wc = (exp_wc + 1) % 65536;
    end
    chain_en = 1'b0;
    checks++; if (b_word_cnt !== 16'd5) begin errors++; $display("FAIL chain_b_word_cnt got %h want 0005", b_word_cnt); end
    checks++; if (word_cnt !== 16'(exp_wc)) begin errors++; $display("FAIL chain_a_word_cnt got %h want %h", word_cnt, 16'(exp_wc)); end
  endtask

  task automatic test_wrap;
    logic [7:0] res; int lat; bit ok;
    force dut.word_cnt_q = 16'hFFFE;
    #1;
    release dut.word_cnt_q;
    checks++; if (word_cnt !== 16'hFFFE) begin errors++; $display("FAIL wrap_preset got %h want FFFE", word_cnt); end
    load_seed(16'hACE1);
    xfer(8'hAA, res, lat, ok);
    checks++; if (word_cnt !== 16'hFFFF) begin errors++; $display("FAIL wrap_ffff got %h want FFFF", word_cnt); end
    load_seed(16'hACE1);
    xfer(8'hAA, res, lat, ok);
    checks++; if (word_cnt !== 16'h0000) begin errors++; $display("FAIL wrap_zero got %h want 0000", word_cnt); end
    checks++; if (res !== 8'h4B) begin errors++; $display("FAIL wrap_data got %h want 4B", res); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_seed();
    test_seed_vs_input();
    test_stall();
    test_seed_mid_gen();
    test_rst_mid_gen();
    test_chain();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
